load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mem_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit_lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size codes
// and the default RAM/ROM decode bit.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RMW_ADDR,
    RMW_WAIT,
    WRITE,
    RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  localparam int unsigned RAM_SELECT_BIT_DEFAULT = 10;

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and memory-side signals of the load/store unit.
// master = requester/memory side, slave = the load/store unit itself.
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_read_write, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_read_write, mem_wdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// merge of a right-aligned store value into a memory word.
module lane_align
  import mem_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [4:0]  w_shamt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_lane_data;

  assign w_shamt = {i_lane, 3'b000};
  assign w_byte  = i_mem_word[w_shamt +: 8];
  assign w_half  = i_mem_word[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = i_mem_word;
    w_mask      = '1;
    case (i_size)
      BYTE: begin
        o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        w_mask      = 32'h0000_00FF << w_shamt;
      end
      HALF: begin
        o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
        w_mask      = 32'h0000_FFFF << {i_lane[1], 4'b0000};
      end
      default: begin
        o_load_data = i_mem_word;
        w_mask      = '1;
      end
    endcase
    w_lane_data   = i_store_data << w_shamt;
    o_merged_word = (i_mem_word & ~w_mask) | (w_lane_data & w_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, performs word-aligned
// memory reads/writes (read-modify-write for sub-word stores) and responds.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned RAM_SELECT_BIT = RAM_SELECT_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  mem_size_t   w_req_size;
  logic        w_accept;
  logic        w_error;

  logic        r_write;
  mem_size_t   r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;

  logic [31:0] w_load_data;
  logic [31:0] w_merged_word;

  assign w_req_size = mem_size_t'(bus.req_size);
  assign w_accept   = bus.req_valid && (r_state == IDLE);

  always_comb begin
    w_error = 1'b0;
    case (w_req_size)
      ILLEGAL: w_error = 1'b1;
      HALF:    w_error = bus.req_addr[0];
      WORD:    w_error = (bus.req_addr[1:0] != 2'b00);
      default: w_error = 1'b0;
    endcase
    if (bus.req_write && !bus.req_addr[RAM_SELECT_BIT]) begin
      w_error = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_error)                w_next = RESP;
          else if (!bus.req_write)    w_next = RD_ADDR;
          else if (w_req_size == WORD) w_next = WRITE;
          else                        w_next = RMW_ADDR;
        end
      end
      RD_ADDR:  w_next = RD_WAIT;
      RD_WAIT:  w_next = RESP;
      RMW_ADDR: w_next = RMW_WAIT;
      RMW_WAIT: w_next = WRITE;
      WRITE:    w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // r_wdata holds the right-aligned store value until RMW_WAIT, then the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_size     <= BYTE;
      r_unsigned <= 1'b0;
      r_lane     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write    <= bus.req_write;
        r_size     <= w_req_size;
        r_unsigned <= bus.req_unsigned;
        r_lane     <= bus.req_addr[1:0];
        r_addr     <= bus.req_addr[31:2];
        r_wdata    <= bus.req_wdata;
        r_rdata    <= '0;
        r_error    <= w_error;
      end
      if (r_state == RD_WAIT) begin
        r_rdata <= w_load_data;
      end
      if (r_state == RMW_WAIT) begin
        r_wdata <= w_merged_word;
      end
    end
  end

  lane_align u_lane_align (
    .i_size        (r_size),
    .i_unsigned    (r_unsigned),
    .i_lane        (r_lane),
    .i_mem_word    (bus.mem_rdata),
    .i_store_data  (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  assign bus.req_ready      = (r_state == IDLE);
  assign bus.resp_valid     = (r_state == RESP);
  assign bus.resp_error     = (r_state == RESP) && r_error;
  assign bus.resp_rdata     = (r_state == RESP && !r_write) ? r_rdata : '0;
  assign bus.mem_address    = {r_addr, 2'b00};
  assign bus.mem_read_write = (r_state == WRITE);
  assign bus.mem_wdata      = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.RAM_SELECT_BIT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem_w [0:511];
  logic [7:0]  ref_b [0:2047];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wcount = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  // Synchronous memory: address sampled at a rising edge, data valid the next cycle.
  always @(posedge clk) begin
    if (bus.mem_read_write) begin
      mem_w[bus.mem_address[10:2]] <= bus.mem_wdata;
      wcount  <= wcount + 1;
      last_wa <= bus.mem_address;
      last_wd <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem_w[bus.mem_address[10:2]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int base);
    int ba;
    ba = base & 'h7FC;
    return {ref_b[ba+3], ref_b[ba+2], ref_b[ba+1], ref_b[ba]};
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit chained, input bit hold, output int waitc);
    if (!chained) @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1;
    bus.req_valid    = hold;
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit chained, input bit hold);
    bit          err;
    logic [31:0] exp_rd;
    logic [15:0] h;
    logic [31:0] ew;
    int          b, nb, exp_lat, lat, waitc, wc0;
    b = int'(a[10:0]);
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
          (w && !a[10]);
    exp_rd = '0;
    if (err) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 3;
      case (sz)
        2'b00: exp_rd = u ? {24'h0, ref_b[b]} : {{24{ref_b[b][7]}}, ref_b[b]};
        2'b01: begin
          h = {ref_b[b+1], ref_b[b]};
          exp_rd = u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: exp_rd = ref_word(b);
      endcase
    end else begin
      exp_lat = (sz == 2'b10) ? 2 : 4;
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int k = 0; k < nb; k++) ref_b[b+k] = wd[8*k +: 8];
    end
    ew  = ref_word(b);
    wc0 = wcount;
    issue(w, sz, u, a, wd, chained, hold, waitc);
    check_val("accept_wait", waitc, chained ? 1 : 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    check_val("latency", lat, exp_lat);
    check_val("resp_error", 32'(bus.resp_error), 32'(err));
    check_val("resp_rdata", bus.resp_rdata, exp_rd);
    check_val("ready_in_resp", 32'(bus.req_ready), 0);
    check_val("write_cycles", wcount - wc0, (w && !err) ? 1 : 0);
    if (w && !err) begin
      check_val("write_addr", last_wa, {a[31:2], 2'b00});
      check_val("write_data", last_wd, ew);
    end
  endtask

  initial begin
    int          waitc, wc0, bad;
    logic [31:0] rw;
    bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
    for (int i = 0; i < 512; i++) begin
      rw = $urandom;
      mem_w[i] = rw;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = rw[8*k +: 8];
    end
    mem_w[256] = 32'h80FF7F01;
    ref_b[1024] = 8'h01;  ref_b[1025] = 8'h7F;  ref_b[1026] = 8'hFF;  ref_b[1027] = 8'h80;

    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(bus.req_ready), 1);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 0);
    check_val("rst_resp_error", 32'(bus.resp_error), 0);
    check_val("rst_resp_rdata", bus.resp_rdata, 0);
    check_val("rst_mem_rw", 32'(bus.mem_read_write), 0);
    check_val("rst_mem_addr", bus.mem_address, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    do_req(1'b0, 2'b00, 1'b0, 32'h401, '0, 0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h403, '0, 0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h403, '0, 0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h402, '0, 0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h402, 32'h000000AA, 0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, '0, 0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF, 0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h404, '0, 0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h401, '0, 0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h402, '0, 0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h400, '0, 0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h12345678, 0, 0);
    do_req(1'b0, 2'b10, 1'b1, 32'h010, '0, 0, 0);

    // Reset during the read phase of a read-modify-write.
    wc0 = wcount;
    issue(1'b1, 2'b00, 1'b0, 32'h400, 32'h55, 0, 0, waitc);
    @(negedge clk);
    check_val("rmw_addr", bus.mem_address, 32'h400);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("abort_ready", 32'(bus.req_ready), 1);
    check_val("abort_resp_valid", 32'(bus.resp_valid), 0);
    check_val("abort_mem_rw", 32'(bus.mem_read_write), 0);
    check_val("abort_mem_addr", bus.mem_address, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_no_resp", 32'(bus.resp_valid), 0);
    check_val("abort_writes", wcount - wc0, 0);
    check_val("abort_mem_word", mem_w[256], ref_word(32'h400));

    // Reset while a word write is on the bus.
    wc0 = wcount;
    issue(1'b1, 2'b10, 1'b0, 32'h408, 32'hCAFEF00D, 0, 0, waitc);
    @(negedge clk);
    check_val("write_state_rw", 32'(bus.mem_read_write), 1);
    reset = 1'b1;
    #1;
    check_val("write_abort_rw", 32'(bus.mem_read_write), 0);
    @(negedge clk);
    reset = 1'b0;
    check_val("write_abort_cnt", wcount - wc0, 0);

    // Back-to-back requests with req_valid held high throughout.
    do_req(1'b0, 2'b10, 1'b0, 32'h404, '0, 0, 1);
    do_req(1'b1, 2'b00, 1'b0, 32'h405, 32'h3C, 1, 1);
    do_req(1'b0, 2'b01, 1'b0, 32'h406, '0, 1, 1);
    do_req(1'b1, 2'b10, 1'b0, 32'h408, 32'h0BADF00D, 1, 0);

    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 2047)),
             $urandom, 0, 0);
    end

    bad = 0;
    for (int i = 0; i < 512; i++) if (mem_w[i] !== ref_word(4*i)) bad++;
    check_val("mem_image", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
